// File: rtl/fuzz_seq_pkg.sv
// Shared types and status codes for the fuzz round sequencer.
package fuzz_seq_pkg;

    typedef enum logic [2:0] {
        HOLD   = 3'd0,
        RUN    = 3'd1,
        IRQ    = 3'd2,
        REPORT = 3'd3,
        RELOAD = 3'd4
    } state_t;

    localparam logic [1:0] ST_PASS    = 2'b00;
    localparam logic [1:0] ST_STALL   = 2'b01;
    localparam logic [1:0] ST_TIMEOUT = 2'b10;

endpackage

// File: rtl/cov_stall_watchdog.sv
// Tracks the last coverage sum and counts cycles without change (saturating).
module cov_stall_watchdog #(
    parameter int COV_W = 30,
    parameter int LIMIT = 1000
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    input  logic [COV_W-1:0] cov,
    output logic             changed,
    output logic             expired
);
    localparam int CW = $clog2(LIMIT) + 1;
    localparam logic [CW-1:0] LAST = CW'(LIMIT - 1);

    logic [CW-1:0]    cnt;
    logic [COV_W-1:0] pre_cov;

    assign changed = (cov != pre_cov);
    // Fires on the LIMIT-th consecutive cycle with no coverage change.
    assign expired = !changed && (cnt == LAST);

    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= '0;
            pre_cov <= '0;
        end else if (clr) begin
            cnt     <= '0;
            pre_cov <= cov;
        end else if (en) begin
            if (changed) begin
                cnt     <= '0;
                pre_cov <= cov;
            end else if (cnt != '1) begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/fuzz_round_sequencer.sv
// Sequences one fuzzing round: DUT reset, run/stall monitoring with msip
// injection, round report and host reload handshake.
module fuzz_round_sequencer
    import fuzz_seq_pkg::*;
#(
    parameter int COV_W       = 30,
    parameter int STALL_LIMIT = 1000,
    parameter int IRQ_LIMIT   = 1000,
    parameter int RST_HOLD    = 4,
    parameter int CNT_W       = 64
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [COV_W-1:0] cov,
    input  logic [63:0]      tohost,
    input  logic [CNT_W-1:0] max_cycles,
    output logic             dut_reset,
    output logic             irq_out,
    output logic             reload_req,
    input  logic             reload_ack,
    output logic             round_done,
    output logic [1:0]       round_status,
    output logic [31:0]      round_count
);
    localparam int ICW = $clog2(IRQ_LIMIT) + 1;
    localparam int HCW = $clog2(RST_HOLD) + 1;
    localparam logic [ICW-1:0] IRQ_LAST  = ICW'(IRQ_LIMIT - 1);
    localparam logic [HCW-1:0] HOLD_LAST = HCW'(RST_HOLD - 1);

    state_t           state, state_nx;
    logic [1:0]       status_nx;
    logic [CNT_W-1:0] budget, cyc_cnt;
    logic [ICW-1:0]   irq_cnt;
    logic [HCW-1:0]   hold_cnt;
    logic             cov_changed, stall_expired;
    logic             budget_hit, irq_expired, active;
    logic             dut_reset_nx, irq_nx, done_nx, reload_nx;
    logic             unused_tohost;

    assign unused_tohost = ^tohost[63:1];
    assign active        = (state == RUN) || (state == IRQ);
    assign budget_hit    = (budget != '0) && ((cyc_cnt + CNT_W'(1)) == budget);
    assign irq_expired   = !cov_changed && (irq_cnt == IRQ_LAST);

    cov_stall_watchdog #(
        .COV_W (COV_W),
        .LIMIT (STALL_LIMIT)
    ) u_stall (
        .clock   (clock),
        .reset   (reset),
        .clr     (state == HOLD),
        .en      (active),
        .cov     (cov),
        .changed (cov_changed),
        .expired (stall_expired)
    );

    // State and registered outputs; outputs follow the state being entered.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state        <= HOLD;
            dut_reset    <= 1'b1;
            irq_out      <= 1'b0;
            reload_req   <= 1'b0;
            round_done   <= 1'b0;
            round_status <= ST_PASS;
            round_count  <= '0;
        end else begin
            state      <= state_nx;
            dut_reset  <= dut_reset_nx;
            irq_out    <= irq_nx;
            reload_req <= reload_nx;
            round_done <= done_nx;
            if (done_nx) begin
                round_status <= status_nx;
                round_count  <= round_count + 1'b1;
            end
        end
    end

    always_comb begin
        state_nx  = state;
        status_nx = round_status;
        case (state)
            HOLD: if (hold_cnt == HOLD_LAST) state_nx = RUN;
            RUN, IRQ: begin
                if (tohost[0]) begin
                    state_nx  = REPORT;
                    status_nx = ST_PASS;
                end else if (budget_hit) begin
                    state_nx  = REPORT;
                    status_nx = ST_TIMEOUT;
                end else if (state == RUN && stall_expired) begin
                    state_nx = IRQ;
                end else if (state == IRQ && cov_changed) begin
                    state_nx = RUN;
                end else if (state == IRQ && irq_expired) begin
                    state_nx  = REPORT;
                    status_nx = ST_STALL;
                end
            end
            REPORT: state_nx = RELOAD;
            RELOAD: if (reload_ack) state_nx = HOLD;
            default: state_nx = HOLD;
        endcase
    end

    always_comb begin
        dut_reset_nx = !((state_nx == RUN) || (state_nx == IRQ));
        irq_nx       = (state_nx == IRQ);
        done_nx      = (state_nx == REPORT);
        reload_nx    = (state_nx == RELOAD);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            hold_cnt <= '0;
            cyc_cnt  <= '0;
            irq_cnt  <= '0;
            budget   <= '0;
        end else begin
            hold_cnt <= (state == HOLD && hold_cnt != HOLD_LAST) ? hold_cnt + 1'b1 : '0;
            if (state == HOLD) begin
                budget  <= max_cycles;
                cyc_cnt <= '0;
            end else if (active && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + 1'b1;
            end
            // IRQ dwell restarts every time IRQ is entered.
            if (state != IRQ)        irq_cnt <= '0;
            else if (irq_cnt != '1)  irq_cnt <= irq_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_fuzz_round_sequencer.sv
// Directed bench for fuzz_round_sequencer with hand-derived cycle timings.
module tb_fuzz_round_sequencer;

    localparam int COV_W = 30;
    localparam int CNT_W = 64;

    logic             clock = 1'b0;
    logic             reset = 1'b0;
    logic [COV_W-1:0] cov = '0;
    logic [63:0]      tohost = '0;
    logic [CNT_W-1:0] max_cycles = '0;
    logic             reload_ack = 1'b0;
    logic             dut_reset, irq_out, reload_req, round_done;
    logic [1:0]       round_status;
    logic [31:0]      round_count;

    int checks = 0;
    int failures = 0;

    fuzz_round_sequencer #(
        .COV_W       (COV_W),
        .STALL_LIMIT (8),
        .IRQ_LIMIT   (5),
        .RST_HOLD    (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cov          (cov),
        .tohost       (tohost),
        .max_cycles   (max_cycles),
        .dut_reset    (dut_reset),
        .irq_out      (irq_out),
        .reload_req   (reload_req),
        .reload_ack   (reload_ack),
        .round_done   (round_done),
        .round_status (round_status),
        .round_count  (round_count)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // From the first HOLD cycle: 4 HOLD cycles, then the first RUN cycle.
    task automatic to_run();
        repeat (3) tick();
        chk("hold_last_dut_reset", dut_reset, 1);
        tick();
        chk("run_entry_dut_reset", dut_reset, 0);
    endtask

    // From REPORT: one RELOAD cycle, immediate ack, back in HOLD.
    task automatic finish_reload();
        tick();
        chk("reload_req_up", {reload_req, dut_reset, round_done}, 3'b110);
        reload_ack = 1'b1;
        tick();
        reload_ack = 1'b0;
        chk("reload_req_drop", {reload_req, dut_reset}, 2'b01);
    endtask

    initial begin
        #400000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic seen;

        // Reset state
        tick();
        tick();
        chk("rst_outputs", {dut_reset, irq_out, reload_req, round_done}, 4'b1000);
        chk("rst_status", round_status, 2'b00);
        chk("rst_count", round_count, 0);
        reset = 1'b1;

        // Pass path: tohost at RUN cycle 50, cov toggling
        to_run();
        seen = 1'b0;
        for (int k = 0; k < 51; k++) begin
            cov = cov + 1'b1;
            tohost = (k == 50) ? 64'd1 : 64'd0;
            if (round_done || irq_out || dut_reset) seen = 1'b1;
            tick();
        end
        tohost = '0;
        chk("pass_quiet_run", seen, 0);
        chk("pass_done", {round_done, dut_reset, irq_out}, 3'b110);
        chk("pass_status", round_status, 2'b00);
        chk("pass_count", round_count, 1);
        tick();
        for (int k = 0; k < 10; k++) begin
            chk("reload_wait", {reload_req, dut_reset, round_done}, 3'b110);
            tick();
        end
        reload_ack = 1'b1;
        tick();
        reload_ack = 1'b0;
        chk("reload_ack_drop", {reload_req, dut_reset}, 2'b01);

        // Stall -> irq -> recovery, with a spurious ack during RUN
        to_run();
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin
            reload_ack = (k == 3);
            if (irq_out || reload_req || dut_reset) seen = 1'b1;
            tick();
        end
        reload_ack = 1'b0;
        chk("stall_pre_irq_quiet", seen, 0);
        chk("irq_on_cycle8", irq_out, 1);
        repeat (3) tick();
        chk("irq_still_on", irq_out, 1);
        cov = cov + 1'b1;
        tick();
        chk("irq_off_after_cov", {irq_out, round_done, dut_reset}, 3'b000);
        tohost = 64'd1;
        tick();
        tohost = '0;
        chk("recov_round_end", {round_done, round_status}, 3'b100);
        chk("recov_count", round_count, 2);
        finish_reload();

        // Stall timeout: done 13 cycles after RUN entry
        to_run();
        repeat (12) tick();
        chk("stall_irq_c12", {irq_out, round_done}, 2'b10);
        tick();
        chk("stall_done_c13", {round_done, irq_out}, 2'b10);
        chk("stall_status", round_status, 2'b01);
        chk("stall_count", round_count, 3);
        finish_reload();

        // Cycle timeout, budget 20
        max_cycles = 64'd20;
        to_run();
        chk("status_held", round_status, 2'b01);
        repeat (19) begin cov = cov + 1'b1; tick(); end
        chk("tmo_not_yet", round_done, 0);
        cov = cov + 1'b1;
        tick();
        chk("tmo_done", {round_done, round_status}, 3'b110);
        chk("tmo_count", round_count, 4);
        finish_reload();

        // Same budget, tohost on the last cycle wins
        to_run();
        repeat (19) begin cov = cov + 1'b1; tick(); end
        cov = cov + 1'b1;
        tohost = 64'd1;
        tick();
        tohost = '0;
        chk("prio_pass", {round_done, round_status}, 3'b100);
        chk("prio_count", round_count, 5);
        finish_reload();

        // Budget of one cycle
        max_cycles = 64'd1;
        to_run();
        cov = cov + 1'b1;
        tick();
        chk("budget1_done", {round_done, round_status}, 3'b110);
        finish_reload();
        max_cycles = '0;

        // Reset while in IRQ
        to_run();
        repeat (9) tick();
        chk("pre_rst_irq", irq_out, 1);
        reset = 1'b0;
        tick();
        chk("rst_irq_outputs", {dut_reset, irq_out, reload_req, round_done}, 4'b1000);
        chk("rst_irq_status", round_status, 2'b00);
        chk("rst_irq_count", round_count, 0);
        reset = 1'b1;

        // Reset while in RELOAD
        max_cycles = 64'd3;
        to_run();
        repeat (3) begin cov = cov + 1'b1; tick(); end
        chk("pre_rst_reload_done", {round_done, round_status}, 3'b110);
        tick();
        chk("pre_rst_reload_req", reload_req, 1);
        reset = 1'b0;
        tick();
        chk("rst_reload_outputs", {dut_reset, irq_out, reload_req, round_done}, 4'b1000);
        chk("rst_reload_count", {round_status, round_count}, 34'd0);
        reset = 1'b1;
        max_cycles = '0;

        // Three back-to-back rounds
        for (int r = 0; r < 3; r++) begin
            to_run();
            cov = cov + 1'b1;
            tohost = 64'd1;
            tick();
            tohost = '0;
            chk("b2b_done", round_done, 1);
            finish_reload();
        end
        chk("b2b_count", round_count, 3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
